// File: rtl/memory_arbiter.sv
// Shares one single-port RAM between the instruction and data ports of two
// cores. A two-state FSM picks a winner in IDLE, then forwards the winner's
// live request to the RAM in BUSY until the RAM reports ACCESS or ERROR.
module memory_arbiter (
   input  logic             CLK,
   input  logic             Rst,
   input  logic [1:0]       iREN,
   input  logic [1:0][31:0] iaddr,
   input  logic [1:0]       dREN,
   input  logic [1:0]       dWEN,
   input  logic [1:0][31:0] daddr,
   input  logic [1:0][31:0] dstore,
   output logic [1:0]       iwait,
   output logic [1:0]       dwait,
   output logic [1:0][31:0] iload,
   output logic [1:0][31:0] dload,
   output logic             ramREN,
   output logic             ramWEN,
   output logic [31:0]      ramaddr,
   output logic [31:0]      ramstore,
   input  logic [31:0]      ramload,
   input  logic [1:0]       ramstate,
   output logic             err
);

   localparam logic [1:0] RAM_FREE   = 2'd0;
   localparam logic [1:0] RAM_BUSY   = 2'd1;
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t state_reg, state_next;
   logic   grant_core_reg, grant_core_next;
   logic   grant_data_reg, grant_data_next;
   logic   last_core_reg, last_core_next;

   logic [1:0] core_req;
   logic       win_core;
   logic       win_data;
   logic       grant_active;
   logic       busy;
   logic       ram_done;

   // A core is requesting if either of its ports is asking for the RAM
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_core_req
         assign core_req[gi] = iREN[gi] | dREN[gi] | dWEN[gi];
      end
   endgenerate

   // Round-robin between cores only on contention; data beats instruction within a core
   always_comb begin
      if (core_req == 2'b11) begin
         win_core = ~last_core_reg;
      end else begin
         win_core = ~core_req[0];
      end
      win_data = dREN[win_core] | dWEN[win_core];
   end

   // The granted port still requesting; if it drops the access is abandoned.
   // Reset overrides BUSY so no completion can be signalled during reset.
   assign grant_active = grant_data_reg ?
                         (dREN[grant_core_reg] | dWEN[grant_core_reg]) :
                         iREN[grant_core_reg];
   assign busy     = (state_reg == BUSY) && !Rst;
   assign ram_done = busy && grant_active &&
                     ((ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR));

   // State, grant and round-robin pointer registers
   always_ff @(posedge CLK) begin
      if (Rst) begin
         state_reg      <= IDLE;
         grant_core_reg <= 1'b0;
         grant_data_reg <= 1'b0;
         last_core_reg  <= 1'b1;
      end else begin
         state_reg      <= state_next;
         grant_core_reg <= grant_core_next;
         grant_data_reg <= grant_data_next;
         last_core_reg  <= last_core_next;
      end
   end

   // Next-state: grant in IDLE, finish on ACCESS/ERROR, abort on dropped request
   always_comb begin
      state_next      = state_reg;
      grant_core_next = grant_core_reg;
      grant_data_next = grant_data_reg;
      last_core_next  = last_core_reg;
      case (state_reg)
         IDLE: begin
            if (|core_req) begin
               state_next      = BUSY;
               grant_core_next = win_core;
               grant_data_next = win_data;
            end
         end
         BUSY: begin
            if (!grant_active) begin
               state_next = IDLE;
            end else if ((ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR)) begin
               state_next     = IDLE;
               last_core_next = grant_core_reg;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs: RAM port follows the granted requester live; waits mirror requests
   // except for the granted port in its completing cycle
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      err      = 1'b0;
      iload    = '0;
      dload    = '0;
      iwait    = iREN;
      dwait    = dREN | dWEN;
      if (busy) begin
         if (grant_data_reg) begin
            ramaddr  = daddr[grant_core_reg];
            ramstore = dstore[grant_core_reg];
            ramWEN   = dWEN[grant_core_reg];
            ramREN   = dREN[grant_core_reg] & ~dWEN[grant_core_reg];
         end else begin
            ramaddr  = iaddr[grant_core_reg];
            ramREN   = iREN[grant_core_reg];
         end
      end
      if (ram_done) begin
         if (grant_data_reg) begin
            dwait[grant_core_reg] = 1'b0;
         end else begin
            iwait[grant_core_reg] = 1'b0;
         end
         if (ramstate == RAM_ERROR) begin
            err = 1'b1;
         end else if (grant_data_reg) begin
            if (!dWEN[grant_core_reg]) begin
               dload[grant_core_reg] = ramload;
            end
         end else begin
            iload[grant_core_reg] = ramload;
         end
      end
   end

endmodule
